// File: rtl/fp_mul_arb.sv
// Round-robin arbiter sharing one pipelined FP32 multiplier among NUM_REQ requesters,
// with an in-order tag FIFO routing results back. Optional perf counters: FP_MUL_ARB_PERF_EN.
module fp_mul_arb #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*32-1:0]           req_a,
  input  logic [NUM_REQ*32-1:0]           req_b,
  input  logic [NUM_REQ*3-1:0]            req_rm,
  output logic                            mul_valid_in,
  output logic [31:0]                     mul_in1,
  output logic [31:0]                     mul_in2,
  output logic [2:0]                      mul_rm,
  input  logic                            mul_valid_out,
  input  logic [31:0]                     mul_out,
  input  logic [3:0]                      mul_flags,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [31:0]                     rsp_data,
  output logic [3:0]                      rsp_flags,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan
`ifdef FP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_issue,
  output logic [31:0]                     perf_stall
`endif
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned PTRW = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNTW = PTRW + 1;

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant_idx_c;
  logic            grant_found_c;
  logic            pop_c;
  logic            full_c;
  logic            accept_c;
  logic [IDXW-1:0] tag_mem [MAX_INFLIGHT];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  function automatic logic [IDXW-1:0] wrap_idx(input int unsigned v);
    return (v >= NUM_REQ) ? IDXW'(v - NUM_REQ) : IDXW'(v);
  endfunction

  // First valid requester at or after the round-robin pointer
  always_comb begin
    grant_idx_c   = rr_ptr;
    grant_found_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found_c && req_valid[wrap_idx(32'(rr_ptr) + k)]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = wrap_idx(32'(rr_ptr) + k);
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign pop_c     = mul_valid_out && (inflight != '0);
  assign full_c    = (inflight == CNTW'(MAX_INFLIGHT));
  assign accept_c  = rst_n && grant_found_c && (!full_c || pop_c);
  assign req_ready = accept_c ? (NUM_REQ'(1) << grant_idx_c) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= '0;
      mul_valid_in <= 1'b0;
      mul_in1      <= '0;
      mul_in2      <= '0;
      mul_rm       <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      err_orphan   <= 1'b0;
    end else begin
      mul_valid_in <= accept_c;
      rsp_valid    <= '0;
      if (accept_c) begin
        mul_in1 <= req_a[32'(grant_idx_c)*32 +: 32];
        mul_in2 <= req_b[32'(grant_idx_c)*32 +: 32];
        mul_rm  <= req_rm[32'(grant_idx_c)*3 +: 3];
        rr_ptr  <= (grant_idx_c == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx_c + 1'b1;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop_c) begin
        rsp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
        rsp_data  <= mul_out;
        rsp_flags <= mul_flags;
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (mul_valid_out && (inflight == '0)) err_orphan <= 1'b1;
      case ({accept_c, pop_c})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (accept_c) tag_mem[wr_ptr] <= grant_idx_c;
  end

`ifdef FP_MUL_ARB_PERF_EN
  // Saturating accept and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (accept_c && (perf_issue != '1)) perf_issue <= perf_issue + 1'b1;
      if ((|req_valid) && !accept_c && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
